gpi_input_conditioner: RTL and testbench
========================================

// Module: gpi_input_conditioner
// PURPOSE
//  Upstream front-end for the APB GPI peripheral. Takes raw, asynchronous, possibly bouncing
//  input pins and produces a clean, synchronous gpi[] bus for the GPI peripheral's input port.
//  Per bit: N-flop synchronizer, stable-count debouncer, and rise/fall edge pulses for a later
//  interrupt stage. All logic sits in the PCLK domain.
// PARAMETERS
//  WIDTH        8     number of input pins (= gpi_pkg::GPI_WIDTH)
//  SYNC_STAGES  2     synchronizer depth, legal >= 2
//  DB_CYCLES    1000  consecutive PCLK cycles a new level must persist to be accepted, legal >= 1
// PORTS
//  PCLK     in   1      clock
//  PRESET   in   1      reset, synchronous, active-high
//  pin_in   in   WIDTH  raw asynchronous pins
//  db_en    in   1      1 = debounce active; 0 = bypass (accept synchronized level every cycle)
//  gpi      out  WIDTH  debounced level, feeds the GPI peripheral's gpi input
//  rise     out  WIDTH  1-cycle pulse per bit when gpi[i] goes 0->1
//  fall     out  WIDTH  1-cycle pulse per bit when gpi[i] goes 1->0
//  changed  out  1      |(rise|fall), registered alongside them
// BEHAVIOUR
//  - Clock and reset: one clock, PCLK; reset is synchronous and active-high on PRESET. On a
//    PCLK edge with PRESET=1, every flop clears: sync chain, counters, gpi, rise, fall, changed.
//  - Synchronizer: sync_q[0] <= pin_in[i]; sync_q[k] <= sync_q[k-1]; syn = sync_q[SYNC_STAGES-1].
//  - Debounce per bit, db_en=1, at each PCLK edge:
//      syn == gpi[i]       -> cnt <= 0                          (glitch cancels progress)
//      syn != gpi[i]:
//        cnt == DB_CYCLES-1  -> gpi[i] <= syn, cnt <= 0
//        otherwise           -> cnt <= cnt + 1
//  - cnt width is $clog2(DB_CYCLES) with a minimum of 1. cnt never exceeds DB_CYCLES-1 and never wraps.
//  - Bypass, db_en=0: gpi[i] <= syn and cnt <= 0 every edge. A db_en change takes effect at the
//    next edge. Switching 1->0 discards any partial count.
//  - Latency from a pin change to gpi:
//      SYNC_STAGES + DB_CYCLES edges with debounce active (6 for 2/4)
//      SYNC_STAGES + 1 in bypass
//  - rise/fall/changed are registered from the gpi next-state versus the current state. They are
//    high in exactly the cycle gpi first shows the new value, for one cycle only, with no
//    back-to-back pulses on one bit unless the debounced level really toggles.
//  - Reset-release edge case: gpi restarts at 0. A pin held high through reset yields gpi=1 and
//    one rise pulse SYNC_STAGES+DB_CYCLES edges after PRESET deasserts.
//  - PRESET asserted mid-count: the count is lost, and outputs read 0 after that edge.
//  - All bits are independent. Simultaneous transitions on any subset produce simultaneous pulses.
// STRUCTURE
//  - gpi_pkg holds localparam GPI_WIDTH = 8 and localparam GPI_DB_DEFAULT = 1000. It is shared
//    with the GPI peripheral.
//  - Sub-module gpi_db_bit holds one bit's sync chain, counter, level, rise and fall.
//  - The top instantiates WIDTH copies in a generate loop and ORs rise|fall into changed.
// TESTING (SYNC_STAGES=2, DB_CYCLES=4, db_en=1 unless stated; edge 0 = first edge after PRESET drop)
//  1 pin_in=0x01 from edge 0, held -> gpi=0x01 from edge 6; rise=0x01 at edge 6 only; changed
//    pulses with it.
//  2 pin_in[1] high for 3 cycles, then low -> gpi stays 0x00; rise, fall and changed never assert.
//  3 Bounce pin_in[2]: 1,0,1,1,1,1... -> counter restarts on the 0. gpi[2]=1 exactly 6 edges
//    after the final 0->1.
//  4 gpi=0xFF settled, then pin_in=0x00 on all bits at once -> gpi=0x00 and fall=0xFF in the
//    same single cycle; rise=0x00.
//  5 db_en=0, pin_in toggles 0->0xA5 -> gpi=0xA5 3 edges later, with rise=0xA5 for one cycle.
//    Re-enable db_en mid-count and confirm the count restarts from 0.
//  6 PRESET pulsed while a bit is at cnt=2 -> all outputs 0 after that edge. With the pin still
//    high, the new rise arrives 6 edges after release.

Source files
------------

// File: rtl/gpi_pkg.sv
// Shared constants for the GPI peripheral and its input conditioner.
package gpi_pkg;

    localparam int GPI_WIDTH      = 8;
    localparam int GPI_DB_DEFAULT = 1000;

    // Debounce counter width: enough bits to hold DB_CYCLES-1, never less than one.
    function automatic int gpi_cnt_width(input int db_cycles);
        int w;
        w = $clog2(db_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gpi_input_conditioner_if.sv
// Pin-side / bus-side signal bundle for the GPI input conditioner.
interface gpi_input_conditioner_if
    import gpi_pkg::*;
#(
    parameter int WIDTH = GPI_WIDTH
);
    logic [WIDTH-1:0] pin_in;
    logic             db_en;
    logic [WIDTH-1:0] gpi;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // Master drives the raw pins and mode; slave is the conditioner itself.
    modport master (output pin_in, db_en, input gpi, rise, fall, changed);
    modport slave  (input pin_in, db_en, output gpi, rise, fall, changed);

endinterface

// File: rtl/gpi_db_bit.sv
// One input bit: synchronizer chain, stable-count debouncer, edge pulses.
module gpi_db_bit
    import gpi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = GPI_DB_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic pin,
    input  logic db_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);
    localparam int             CW      = gpi_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, fall_q;

    assign syn = sync_q[SYNC_STAGES-1];

    // Synchronizer chain shifting the raw pin into the PCLK domain.
    // NOTE: the sync flops are reset too, so a pin held high through reset
    // re-enters the pipeline cleanly instead of appearing as a stale level.
    always_ff @(posedge PCLK) begin
        if (PRESET) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    // Next-state for the debounce counter and the accepted level.
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (!db_en) begin
            level_d = syn;
        end else if (syn != level_q) begin
            if (cnt_q == CNT_MAX) level_d = syn;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    assign rise_nxt = level_d & ~level_q;
    assign fall_nxt = ~level_d & level_q;

    // Level, counter and edge-pulse registers.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/gpi_input_conditioner.sv
// Raw-pin front end for the GPI peripheral: WIDTH independent conditioned bits.
module gpi_input_conditioner
    import gpi_pkg::*;
#(
    parameter int WIDTH       = GPI_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = GPI_DB_DEFAULT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    gpi_input_conditioner_if.slave  bus
);
    logic [WIDTH-1:0] gpi_w, rise_w, fall_w, rise_nxt_w, fall_nxt_w;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpi_db_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_bit (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .pin      (bus.pin_in[i]),
            .db_en    (bus.db_en),
            .level    (gpi_w[i]),
            .rise     (rise_w[i]),
            .fall     (fall_w[i]),
            .rise_nxt (rise_nxt_w[i]),
            .fall_nxt (fall_nxt_w[i])
        );
    end

    // Summary change flag, registered in the same cycle as the per-bit pulses.
    always_ff @(posedge PCLK) begin
        if (PRESET) changed_q <= 1'b0;
        else        changed_q <= |(rise_nxt_w | fall_nxt_w);
    end

    assign bus.gpi     = gpi_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Directed test of the GPI input conditioner with SYNC_STAGES=2, DB_CYCLES=4.
module tb_gpi_input_conditioner;

    localparam int W = 8;

    logic PCLK;
    logic PRESET;
    int   n_checks = 0;
    int   n_errors = 0;

    gpi_input_conditioner_if #(.WIDTH(W)) bus ();

    gpi_input_conditioner #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance n edges; outputs are then sampled 1 time unit after the last edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] g, input logic [W-1:0] r,
                             input logic [W-1:0] f, input logic c);
        check({tag, ".gpi"},     32'(bus.gpi),     32'(g));
        check({tag, ".rise"},    32'(bus.rise),    32'(r));
        check({tag, ".fall"},    32'(bus.fall),    32'(f));
        check({tag, ".changed"}, 32'(bus.changed), 32'(c));
    endtask

    initial begin
        PRESET     = 1'b1;
        bus.pin_in = '0;
        bus.db_en  = 1'b1;
        tick(3);
        check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);

        // 1: single bit rises and is accepted after 6 edges.
        PRESET = 1'b0;
        tick(1);                            // edge 0
        bus.pin_in = 8'h01;
        tick(5);                            // edge 5
        check_all("t1_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);                            // edge 6
        check_all("t1_e6", 8'h01, 8'h01, 8'h00, 1'b1);
        tick(1);
        check_all("t1_e7", 8'h01, 8'h00, 8'h00, 1'b0);

        // 2: 3-cycle pulse on bit 1 is rejected.
        bus.pin_in = 8'h03;
        tick(3);
        bus.pin_in = 8'h01;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_all("t2_short", 8'h01, 8'h00, 8'h00, 1'b0);
        end

        // 3: bounce 1,0,1... on bit 2; acceptance 6 edges after the final 0->1.
        bus.pin_in = 8'h05;
        tick(1);
        bus.pin_in = 8'h01;
        tick(1);
        bus.pin_in = 8'h05;
        tick(5);
        check_all("t3_e5", 8'h01, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t3_e6", 8'h05, 8'h04, 8'h00, 1'b1);

        // 4: all bits high, then all drop together.
        tick(2);
        bus.pin_in = 8'hFF;
        tick(6);
        check_all("t4_up", 8'hFF, 8'hFA, 8'h00, 1'b1);
        tick(2);
        bus.pin_in = 8'h00;
        tick(5);
        check_all("t4_e5", 8'hFF, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t4_e6", 8'h00, 8'h00, 8'hFF, 1'b1);
        tick(1);
        check_all("t4_e7", 8'h00, 8'h00, 8'h00, 1'b0);

        // 5a: bypass follows the pin after 3 edges.
        bus.db_en  = 1'b0;
        bus.pin_in = 8'hA5;
        tick(2);
        check_all("t5_e2", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t5_e3", 8'hA5, 8'hA5, 8'h00, 1'b1);
        tick(1);
        check_all("t5_e4", 8'hA5, 8'h00, 8'h00, 1'b0);

        // 5b: change enters while bypassed, debounce re-enabled before it lands:
        // the full debounce count applies from when the synchronized level changes.
        tick(2);
        bus.pin_in = 8'h00;
        tick(1);
        bus.db_en = 1'b1;
        tick(2);                            // edge 3: bypass would have switched here
        check_all("t5_reen_e3", 8'hA5, 8'h00, 8'h00, 1'b0);
        tick(2);
        check_all("t5_reen_e5", 8'hA5, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t5_reen_e6", 8'h00, 8'h00, 8'hA5, 1'b1);

        // 6: reset mid-count on bit 4, pin stays high across reset.
        tick(2);
        bus.pin_in = 8'h10;
        tick(4);                            // count at 2
        check_all("t6_pre", 8'h00, 8'h00, 8'h00, 1'b0);
        PRESET = 1'b1;
        tick(1);
        check_all("t6_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        PRESET = 1'b0;
        tick(5);
        check_all("t6_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t6_e6", 8'h10, 8'h10, 8'h00, 1'b1);
        tick(1);
        check_all("t6_e7", 8'h10, 8'h00, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
